el2_bp_ghr_tracker: RTL and testbench

Branch-predictor global-history tracker in the IFU. Maintains the speculative global history register (GHR) that feeds the BHT index hash alongside the BTB index hash, and a committed GHR advanced by in-order branch resolution. Each fetch-stage prediction checkpoints the pre-update history into a small in-order FIFO. Mispredicts restore history from the oldest checkpoint; flushes restore it from the committed copy.

---
 rtl/el2_bp_ghr_tracker.sv | 87 ++++++++
 tb/tb_el2_bp_ghr_tracker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/el2_bp_ghr_tracker.sv
// Global-history tracker for the branch predictor: speculative and committed GHRs
// plus an in-order checkpoint FIFO used to repair history on mispredict or flush.
module el2_bp_ghr_tracker #(
   parameter int GHR_SIZE   = 8,
   parameter int CKPT_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              pred_valid,
   input  logic                              pred_taken,
   output logic                              pred_ready,
   input  logic                              res_valid,
   input  logic                              res_taken,
   input  logic                              res_mispredict,
   input  logic                              flush,
   output logic [GHR_SIZE-1:0]               ghr_spec,
   output logic [GHR_SIZE-1:0]               ghr_commit,
   output logic [$clog2(CKPT_DEPTH):0]       ckpt_count,
   output logic                              res_err
);

   localparam int PTR_W = $clog2(CKPT_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [GHR_SIZE-1:0] ckpt_mem [CKPT_DEPTH];
   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic                push;
   logic                pop;
   logic                squash;

   function automatic logic [GHR_SIZE-1:0] shift_in(input logic [GHR_SIZE-1:0] g,
                                                    input logic t);
      shift_in = {g[GHR_SIZE-2:0], t};
   endfunction

   // A prediction is consumed only on pred_valid & pred_ready; ready looks at the
   // registered count only, so a same-cycle resolution never frees a full slot early.
   assign pred_ready = (ckpt_count < CNT_W'(CKPT_DEPTH));
   assign push       = pred_valid & pred_ready;
   assign pop        = res_valid & (ckpt_count != '0);
   assign squash     = pop & res_mispredict;

   // Checkpoint storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (!rst && !flush && !squash && push) begin
         ckpt_mem[tail] <= ghr_spec;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_spec   <= '0;
         ghr_commit <= '0;
         ckpt_count <= '0;
         head       <= '0;
         tail       <= '0;
         res_err    <= 1'b0;
      end else begin
         res_err <= res_valid & (ckpt_count == '0) & ~flush;
         if (flush) begin
            ghr_spec   <= ghr_commit;
            ckpt_count <= '0;
            head       <= '0;
            tail       <= '0;
         end else if (squash) begin
            // Younger branches are squashed, so the same-cycle prediction is dropped too.
            ghr_spec   <= shift_in(ckpt_mem[head], res_taken);
            ghr_commit <= shift_in(ghr_commit, res_taken);
            ckpt_count <= '0;
            head       <= '0;
            tail       <= '0;
         end else begin
            if (pop) begin
               ghr_commit <= shift_in(ghr_commit, res_taken);
               head       <= head + PTR_W'(1);
            end
            if (push) begin
               ghr_spec <= shift_in(ghr_spec, pred_taken);
               tail     <= tail + PTR_W'(1);
            end
            ckpt_count <= ckpt_count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

endmodule

// File: tb/tb_el2_bp_ghr_tracker.sv
// Self-checking bench for el2_bp_ghr_tracker: directed scenarios plus randomized
// traffic checked against a queue-based history model.
module tb_el2_bp_ghr_tracker;

   localparam int GW = 8;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          pred_valid = 1'b0;
   logic          pred_taken = 1'b0;
   logic          pred_ready;
   logic          res_valid = 1'b0;
   logic          res_taken = 1'b0;
   logic          res_mispredict = 1'b0;
   logic          flush = 1'b0;
   logic [GW-1:0] ghr_spec;
   logic [GW-1:0] ghr_commit;
   logic [2:0]    ckpt_count;
   logic          res_err;

   int checks = 0;
   int errors = 0;

   // Reference model: checkpoint queue and the two histories.
   logic [GW-1:0] m_q[$];
   logic [GW-1:0] m_spec;
   logic [GW-1:0] m_commit;
   logic          m_err;

   el2_bp_ghr_tracker #(.GHR_SIZE(GW), .CKPT_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
      .flush(flush), .ghr_spec(ghr_spec), .ghr_commit(ghr_commit),
      .ckpt_count(ckpt_count), .res_err(res_err)
   );

   always #5 clk = ~clk;

   function automatic logic [GW-1:0] sh(input logic [GW-1:0] g, input logic t);
      return {g[GW-2:0], t};
   endfunction

   task automatic model_step(input logic rs, input logic pv, input logic pt, input logic rv,
                             input logic rt, input logic rm, input logic fl);
      bit ready;
      ready = (m_q.size() < DEPTH);
      if (rs) begin
         m_spec = '0; m_commit = '0; m_q.delete(); m_err = 1'b0;
      end else begin
         m_err = rv && (m_q.size() == 0) && !fl;
         if (fl) begin
            m_spec = m_commit;
            m_q.delete();
         end else if (rv && m_q.size() > 0 && rm) begin
            m_spec = sh(m_q[0], rt);
            m_commit = sh(m_commit, rt);
            m_q.delete();
         end else begin
            if (rv && m_q.size() > 0) begin
               void'(m_q.pop_front());
               m_commit = sh(m_commit, rt);
            end
            if (pv && ready) begin
               m_q.push_back(m_spec);
               m_spec = sh(m_spec, pt);
            end
         end
      end
   endtask

   // One clock: apply inputs, advance model, sample #1 after the edge, idle inputs.
   task automatic drive(input logic rs, input logic pv, input logic pt, input logic rv,
                        input logic rt, input logic rm, input logic fl);
      rst = rs; pred_valid = pv; pred_taken = pt; res_valid = rv;
      res_taken = rt; res_mispredict = rm; flush = fl;
      model_step(rs, pv, pt, rv, rt, rm, fl);
      @(posedge clk);
      #1;
      rst = 0; pred_valid = 0; pred_taken = 0; res_valid = 0;
      res_taken = 0; res_mispredict = 0; flush = 0;
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0, 0);
      checks++; if (ghr_spec !== 8'h00) begin errors++; $display("FAIL reset_spec got %h exp 00", ghr_spec); end
      checks++; if (ghr_commit !== 8'h00) begin errors++; $display("FAIL reset_commit got %h exp 00", ghr_commit); end
      checks++; if (ckpt_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ckpt_count); end
      checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", pred_ready); end
      checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", res_err); end
   endtask

   task automatic test_fill();
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      checks++; if (ghr_spec !== 8'h0B) begin errors++; $display("FAIL fill_spec got %h exp 0b", ghr_spec); end
      checks++; if (ckpt_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", ckpt_count); end
      checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", pred_ready); end
      checks++; if (ghr_commit !== 8'h00) begin errors++; $display("FAIL fill_commit got %h exp 00", ghr_commit); end
   endtask

   task automatic test_full_hold();
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      checks++; if (ghr_spec !== 8'h0B) begin errors++; $display("FAIL full_spec got %h exp 0b", ghr_spec); end
      checks++; if (ckpt_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", ckpt_count); end
      // Pop with a prediction in the same cycle: still full, so no push.
      drive(0, 1, 1, 1, 1, 0, 0);
      checks++; if (ckpt_count !== 3'd3) begin errors++; $display("FAIL pop_count got %0d exp 3", ckpt_count); end
      checks++; if (ghr_commit !== 8'h01) begin errors++; $display("FAIL pop_commit got %h exp 01", ghr_commit); end
      checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL pop_ready got %b exp 1", pred_ready); end
      checks++; if (ghr_spec !== 8'h0B) begin errors++; $display("FAIL pop_spec got %h exp 0b", ghr_spec); end
   endtask

   task automatic test_mispredict();
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 1, 1, 0, 1, 0);
      checks++; if (ghr_spec !== 8'h00) begin errors++; $display("FAIL mis_spec got %h exp 00", ghr_spec); end
      checks++; if (ckpt_count !== 3'd0) begin errors++; $display("FAIL mis_count got %0d exp 0", ckpt_count); end
      checks++; if (ghr_commit !== 8'h00) begin errors++; $display("FAIL mis_commit got %h exp 00", ghr_commit); end
   endtask

   task automatic test_flush();
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      checks++; if (ghr_commit !== 8'h05 || ghr_spec !== 8'h2B || ckpt_count !== 3'd2) begin
         errors++; $display("FAIL flush_setup got %h/%h/%0d exp 05/2b/2", ghr_commit, ghr_spec, ckpt_count);
      end
      drive(0, 0, 0, 1, 1, 0, 1);
      checks++; if (ghr_spec !== 8'h05) begin errors++; $display("FAIL flush_spec got %h exp 05", ghr_spec); end
      checks++; if (ckpt_count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", ckpt_count); end
      checks++; if (ghr_commit !== 8'h05) begin errors++; $display("FAIL flush_commit got %h exp 05", ghr_commit); end
      checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL flush_err got %b exp 0", res_err); end
   endtask

   task automatic test_res_err();
      drive(0, 0, 0, 1, 1, 1, 0);
      checks++; if (res_err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", res_err); end
      checks++; if (ghr_spec !== 8'h05 || ghr_commit !== 8'h05 || ckpt_count !== 3'd0) begin
         errors++; $display("FAIL err_state got %h/%h/%0d exp 05/05/0", ghr_spec, ghr_commit, ckpt_count);
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", res_err); end
   endtask

   task automatic test_back_to_back();
      logic [0:0]    exp_q[$];
      logic [GW-1:0] hist_q[$];
      logic          d;
      drive(1, 0, 0, 0, 0, 0, 0);
      hist_q.push_back(m_spec);
      for (int i = 0; i < 2; i++) begin
         d = 1'($urandom_range(0, 1));
         exp_q.push_back(d);
         drive(0, 1, d, 0, 0, 0, 0);
         hist_q.push_back(m_spec);
      end
      for (int i = 0; i < 20; i++) begin
         d = 1'($urandom_range(0, 1));
         exp_q.push_back(d);
         drive(0, 1, d, 1, exp_q.pop_front(), 0, 0);
         hist_q.push_back(m_spec);
         checks++; if (ckpt_count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 2", i, ckpt_count); end
         checks++; if (ghr_spec !== m_spec) begin errors++; $display("FAIL b2b_spec[%0d] got %h exp %h", i, ghr_spec, m_spec); end
         checks++; if (ghr_commit !== hist_q[hist_q.size()-3]) begin
            errors++; $display("FAIL b2b_commit[%0d] got %h exp %h", i, ghr_commit, hist_q[hist_q.size()-3]);
         end
      end
   endtask

   task automatic test_random();
      logic rs, pv, pt, rv, rt, rm, fl;
      for (int i = 0; i < 300; i++) begin
         rs = ($urandom_range(0, 99) == 0);
         fl = ($urandom_range(0, 29) == 0);
         pv = ($urandom_range(0, 99) < 60);
         pt = 1'($urandom_range(0, 1));
         rv = ($urandom_range(0, 99) < 45);
         rt = 1'($urandom_range(0, 1));
         rm = ($urandom_range(0, 9) == 0);
         drive(rs, pv, pt, rv, rt, rm, fl);
         checks++; if (ghr_spec !== m_spec) begin errors++; $display("FAIL rnd_spec[%0d] got %h exp %h", i, ghr_spec, m_spec); end
         checks++; if (ghr_commit !== m_commit) begin errors++; $display("FAIL rnd_commit[%0d] got %h exp %h", i, ghr_commit, m_commit); end
         checks++; if (ckpt_count !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, ckpt_count, m_q.size()); end
         checks++; if (pred_ready !== (m_q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready[%0d] got %b", i, pred_ready); end
         checks++; if (res_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got %b exp %b", i, res_err, m_err); end
      end
   endtask

   initial begin
      m_spec = '0; m_commit = '0; m_err = 1'b0;
      @(negedge clk);
      test_reset();
      test_fill();
      test_full_hold();
      test_mispredict();
      test_flush();
      test_res_err();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
